ysyx_22050612_ifu: RTL and testbench
====================================

Name: ysyx_22050612_ifu

Overview:
- Instruction fetch unit; sits directly upstream of the execute stage (via the decoder).
- Owns the architectural PC and issues one 32-bit fetch per instruction over a valid/ready instruction-memory port.
- Presents the instruction and its PC downstream, then waits for the execute stage to return dnpc before starting the next fetch.
- Non-pipelined: exactly one instruction in flight, matching the current single-issue core.

Parameters:
RESET_PC  64'h0000_0000_8000_0000  PC loaded on reset
CNT_W     64  width of retired-fetch counter

Ports:
clk              in   1   clock, rising edge
rst_n            in   1   synchronous reset, active-low
imem_req_valid   out  1   fetch request valid
imem_req_ready   in   1   memory accepts request
imem_addr        out  64  fetch address (= pc)
imem_resp_valid  in   1   response data valid (one-cycle pulse)
imem_resp_data   in   32  fetched instruction
imem_resp_err    in   1   access fault, qualified by resp_valid
inst_valid       out  1   instruction available downstream
inst_ready       in   1   downstream consumes instruction
inst             out  32  instruction word (registered)
inst_pc          out  64  PC of inst
fetch_fault      out  1   inst is invalid: misaligned or memory error
dnpc_valid       in   1   execute stage presents next PC
dnpc             in   64  next PC from execute stage
fetch_cnt        out  CNT_W  count of instructions handed downstream

Behaviour:
- Clock and reset: single clock clk; rst_n synchronous, active-low. All state updates on the rising edge of clk.
- Reset: on any edge with rst_n=0 →
  - state=RST, pc=RESET_PC, inst=32'h0, inst_pc=0, fetch_fault=0, fetch_cnt=0.
  - All handshake outputs are decoded from state, so imem_req_valid=0 and inst_valid=0 in RST.
  - Reset mid-operation aborts any state. Memory shares rst_n, so no stale response is expected; any imem_resp_valid outside WAIT is ignored.
- States: RST, REQ, WAIT, HOLD, NPC.
  - RST: next cycle → REQ.
  - REQ: imem_req_valid=1, imem_addr=pc. Fire on imem_req_ready=1 → WAIT. Address stays stable while waiting for ready.
  - WAIT: on imem_resp_valid → inst<=imem_resp_data, inst_pc<=pc, fetch_fault<=imem_resp_err, → HOLD. Minimum fetch latency is REQ→HOLD in 2 cycles when memory responds the cycle after acceptance.
  - HOLD: inst_valid=1. inst, inst_pc and fetch_fault are held stable until accepted. On inst_ready=1 → fetch_cnt+=1 (wraps modulo 2^CNT_W), → NPC.
  - NPC: on dnpc_valid=1 → pc<=dnpc.
    - If dnpc[1:0]==0 → REQ.
    - Else (misaligned) → no memory request; inst<=32'h0000_0013 (nop), inst_pc<=dnpc, fetch_fault<=1, → HOLD.
- dnpc_valid is ignored outside NPC.
- imem_resp_valid is ignored outside WAIT.
- inst_ready is ignored outside HOLD.
- Arithmetic: pc is 64 bits; it is only loaded, never incremented here (execute stage computes pc+4). fetch_cnt is unsigned and wraps.
- Simultaneous events:
  - imem_req_ready and imem_resp_valid in the same REQ cycle: the response is ignored. Memory must respond no earlier than the cycle after acceptance.
  - Reset has priority over every transition.

Decomposition:
- Shared package ysyx_22050612_pkg holds:
  - state encoding constants: RST=3'd0, REQ=1, WAIT=2, HOLD=3, NPC=4
  - RESET_PC
  - NOP_INST=32'h0000_0013
  - INST_W=32, XLEN=64
- One natural sub-module: ysyx_22050612_ifu_fsm (state register + next-state/handshake decode). Datapath registers (pc, inst, inst_pc, fault, counter) stay in the top.

Test Plan:
- Reset release with memory always ready, 1-cycle response 32'h00000513 → imem_addr=64'h80000000 on first REQ cycle; inst_valid rises 2 cycles after REQ; inst=32'h00000513, inst_pc=64'h80000000, fetch_cnt=1 after inst_ready.
- imem_req_ready held low 3 cycles → imem_req_valid stays 1 and imem_addr stays stable; exactly one request is accepted.
- inst_ready low 4 cycles in HOLD, then dnpc_valid=1 with dnpc=64'h80000004 in NPC → outputs stable throughout; next imem_addr=64'h80000004.
- dnpc=64'h80000006 → no imem_req_valid; HOLD with fetch_fault=1, inst=32'h00000013, inst_pc=64'h80000006.
- imem_resp_err=1 with data 32'hDEADBEEF → fetch_fault=1, inst=32'hDEADBEEF, inst_pc=current pc.
- rst_n=0 during WAIT → next cycle state RST, both valids 0, fetch_cnt=0; refetch starts at 64'h80000000.

Source files
------------

// File: rtl/ysyx_22050612_pkg.sv
// Shared constants and types for the ysyx_22050612 instruction fetch unit.
// State codes are plain constants so older tools and waveform scripts can decode them.
package ysyx_22050612_pkg;

    localparam int XLEN   = 64;
    localparam int INST_W = 32;

    localparam logic [XLEN-1:0]   RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    localparam logic [2:0] RST  = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] HOLD = 3'd3;
    localparam logic [2:0] NPC  = 3'd4;

    // Instruction as presented downstream, held as one register group.
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   pc;
        logic              fault;
    } inst_pkt_t;

endpackage

// File: rtl/ysyx_22050612_ifu_if.sv
// Fetch unit bus: instruction-memory port, downstream instruction port and dnpc return.
// master is the fetch unit's view; slave is the memory/execute side.
interface ysyx_22050612_ifu_if;
    import ysyx_22050612_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN-1:0]   imem_addr;
    logic              imem_resp_valid;
    logic [INST_W-1:0] imem_resp_data;
    logic              imem_resp_err;

    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   inst_pc;
    logic              fetch_fault;

    logic              dnpc_valid;
    logic [XLEN-1:0]   dnpc;

    modport master (
        output imem_req_valid, imem_addr, inst_valid, inst, inst_pc, fetch_fault,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
        input  inst_ready, dnpc_valid, dnpc
    );

    modport slave (
        input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc, fetch_fault,
        output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
        output inst_ready, dnpc_valid, dnpc
    );

endinterface

// File: rtl/ysyx_22050612_ifu_fsm.sv
// Fetch sequencing: one instruction in flight, request -> response -> hand-off -> next pc.
// Handshake valids are pure decodes of the state register.
module ysyx_22050612_ifu_fsm
    import ysyx_22050612_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_ready,
    input  logic       resp_valid,
    input  logic       inst_ready,
    input  logic       dnpc_valid,
    input  logic       dnpc_misaligned,
    output logic [2:0] state,
    output logic       req_valid,
    output logic       inst_valid
);

    logic [2:0] state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            RST:     state_nxt = REQ;
            REQ:     if (req_ready)  state_nxt = WAIT;
            WAIT:    if (resp_valid) state_nxt = HOLD;
            HOLD:    if (inst_ready) state_nxt = NPC;
            // A misaligned target never reaches memory; it is reported as a faulting nop.
            NPC:     if (dnpc_valid) state_nxt = dnpc_misaligned ? HOLD : REQ;
            default: state_nxt = RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= RST;
        else        state <= state_nxt;
    end

    assign req_valid  = (state == REQ);
    assign inst_valid = (state == HOLD);

endmodule

// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch unit: owns the architectural pc, fetches one word per instruction
// and waits for the execute stage's dnpc before the next fetch.
module ysyx_22050612_ifu #(
    parameter logic [63:0] RESET_PC = ysyx_22050612_pkg::RESET_PC,
    parameter int          CNT_W    = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ysyx_22050612_ifu_if.master    bus,
    output logic [CNT_W-1:0]       fetch_cnt
);
    import ysyx_22050612_pkg::*;

    logic [2:0]      state;
    logic [XLEN-1:0] pc;
    inst_pkt_t       held;
    logic            misaligned;

    assign misaligned = (bus.dnpc[1:0] != 2'b00);

    ysyx_22050612_ifu_fsm u_fsm (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_ready       (bus.imem_req_ready),
        .resp_valid      (bus.imem_resp_valid),
        .inst_ready      (bus.inst_ready),
        .dnpc_valid      (bus.dnpc_valid),
        .dnpc_misaligned (misaligned),
        .state           (state),
        .req_valid       (bus.imem_req_valid),
        .inst_valid      (bus.inst_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            held      <= '0;
            fetch_cnt <= '0;
        end else begin
            case (state)
                WAIT: if (bus.imem_resp_valid)
                    held <= '{bus.imem_resp_data, pc, bus.imem_resp_err};
                HOLD: if (bus.inst_ready)
                    fetch_cnt <= fetch_cnt + CNT_W'(1);
                NPC: if (bus.dnpc_valid) begin
                    pc <= bus.dnpc;
                    if (misaligned) held <= '{NOP_INST, bus.dnpc, 1'b1};
                end
                default: ;
            endcase
        end
    end

    // pc only changes in NPC, so the address is stable for the whole REQ wait.
    assign bus.imem_addr   = pc;
    assign bus.inst        = held.inst;
    assign bus.inst_pc     = held.pc;
    assign bus.fetch_fault = held.fault;

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Randomized bench for the fetch unit: a memory/execute responder issues stimulus and
// records expected fetch addresses and instructions; a negedge monitor checks them.
module tb_ysyx_22050612_ifu;
    import ysyx_22050612_pkg::*;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] fetch_cnt;

    ysyx_22050612_ifu_if bus();

    ysyx_22050612_ifu #(.RESET_PC(64'h0000_0000_8000_0000), .CNT_W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .fetch_cnt (fetch_cnt)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] exp_addr[$];
    exp_t        exp_inst[$];
    logic        resp_legit = 1'b0;
    logic [63:0] model_pc;
    logic        mem_busy, owe;
    int          mem_lat;
    logic        req_fire, inst_fire, dnpc_fire;
    int          n_err = 0, n_mis = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle out of reset, compare presented outputs with the model queues.
    logic [63:0] mon_cnt = 0;
    logic        prev_legit = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_cnt    = 0;
            prev_legit = 1'b0;
        end else begin
            if (prev_legit) chk("resp_to_inst_valid", 64'(bus.inst_valid), 64'd1);
            prev_legit = resp_legit;
            chk("fetch_cnt", fetch_cnt, mon_cnt);
            chk("valid_excl", 64'(bus.imem_req_valid & bus.inst_valid), 64'd0);
            if (bus.imem_req_valid) begin
                if (exp_addr.size() == 0) chk("unexpected_req", 64'(bus.imem_req_valid), 64'd0);
                else begin
                    chk("imem_addr", bus.imem_addr, exp_addr[0]);
                    if (bus.imem_req_ready) void'(exp_addr.pop_front());
                end
            end
            if (bus.inst_valid) begin
                if (exp_inst.size() == 0) chk("unexpected_inst", 64'(bus.inst_valid), 64'd0);
                else begin
                    chk("inst", 64'(bus.inst), 64'(exp_inst[0].inst));
                    chk("inst_pc", bus.inst_pc, exp_inst[0].pc);
                    chk("fetch_fault", 64'(bus.fetch_fault), 64'(exp_inst[0].fault));
                    if (bus.inst_ready) begin
                        void'(exp_inst.pop_front());
                        mon_cnt++;
                    end
                end
            end
        end
    end

    function automatic logic [63:0] gen_dnpc();
        logic [63:0] a;
        a = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                        : {32'h0, 32'h8000_0000 | ($urandom & 32'h0fff_ffff)};
        a[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        return a;
    endfunction

    // Reset with every input asserted to show reset dominates; checks the reset state.
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        exp_addr.delete();
        exp_inst.delete();
        mem_busy = 1'b0; owe = 1'b0; mem_lat = 0; resp_legit = 1'b0;
        req_fire = 1'b0; inst_fire = 1'b0; dnpc_fire = 1'b0;
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hFFFF_FFFF;
        bus.imem_resp_err   = 1'b1;
        bus.inst_ready      = 1'b1;
        bus.dnpc_valid      = 1'b1;
        bus.dnpc            = 64'h4;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
            chk("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
            chk("rst_fetch_cnt", fetch_cnt, 64'd0);
            chk("rst_inst", 64'(bus.inst), 64'd0);
            chk("rst_inst_pc", bus.inst_pc, 64'd0);
            chk("rst_fault", 64'(bus.fetch_fault), 64'd0);
            chk("rst_addr", bus.imem_addr, 64'h0000_0000_8000_0000);
        end
        model_pc = 64'h0000_0000_8000_0000;
        exp_addr.push_back(model_pc);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic did_mid_reset;
        did_mid_reset = 1'b0;
        do_reset(3);
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (req_fire) begin
                mem_busy = 1'b1;
                mem_lat  = $urandom_range(0, 3);
            end
            if (inst_fire) owe = 1'b1;
            if (dnpc_fire) begin
                owe      = 1'b0;
                model_pc = bus.dnpc;
                if (model_pc[1:0] == 2'b00) exp_addr.push_back(model_pc);
                else begin
                    exp_inst.push_back('{NOP_INST, model_pc, 1'b1});
                    n_mis++;
                end
            end
            if (cyc >= 3000 && !did_mid_reset && mem_busy && mem_lat > 0) begin
                did_mid_reset = 1'b1;
                do_reset(2);
            end

            bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            resp_legit = 1'b0;
            if (mem_busy && mem_lat == 0) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = $urandom;
                bus.imem_resp_err   = ($urandom_range(0, 7) == 0);
                exp_inst.push_back('{bus.imem_resp_data, model_pc, bus.imem_resp_err});
                if (bus.imem_resp_err) n_err++;
                resp_legit = 1'b1;
                mem_busy   = 1'b0;
            end else begin
                if (mem_busy) mem_lat--;
                // Stray pulses while no fetch is outstanding must be ignored.
                bus.imem_resp_valid = !mem_busy && ($urandom_range(0, 7) == 0);
                bus.imem_resp_data  = $urandom;
                bus.imem_resp_err   = 1'($urandom);
            end
            bus.inst_ready = ($urandom_range(0, 1) == 0);
            bus.dnpc_valid = owe ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0);
            bus.dnpc       = gen_dnpc();

            @(negedge clk);
            req_fire  = bus.imem_req_valid && bus.imem_req_ready;
            inst_fire = bus.inst_valid && bus.inst_ready;
            dnpc_fire = owe && bus.dnpc_valid;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("progress", 64'(fetch_cnt >= 64'd100), 64'd1);
        chk("mid_reset_done", 64'(did_mid_reset), 64'd1);
        $display("coverage: %0d memory faults, %0d misaligned targets", n_err, n_mis);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
